// File: rtl/contador_display.sv
// 4-bit up-counter with enable feeding a registered hex-to-7-segment converter.
// Define DISPLAY_HEX_EN to show A..F for codes 10..15; otherwise those codes blank the digit.
module contador_display #(
  parameter int COUNT_MAX      = 15,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [3:0] saida,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic       s5,
  output logic       s6,
  output logic       s7
);

  localparam logic [3:0] LAST_COUNT = 4'(COUNT_MAX);
  // XOR mask applied to the active-high pattern to get the pin polarity.
  localparam logic [6:0] SEG_POL    = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [6:0] SEG_RESET  = 7'b1111110 ^ SEG_POL;

  // Active-high abcdefg pattern; every code has a defined result.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    case (code)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
`ifdef DISPLAY_HEX_EN
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b0011111;
      4'hC: hex_to_seg = 7'b1001110;
      4'hD: hex_to_seg = 7'b0111101;
      4'hE: hex_to_seg = 7'b1001111;
      4'hF: hex_to_seg = 7'b1000111;
`endif
      default: hex_to_seg = 7'b0000000;
    endcase
  endfunction

  logic [3:0] count_q;
  logic [3:0] count_next;
  logic [6:0] seg_q;
  logic [6:0] seg_next;

  // NOTE: a default assignment before the branches keeps always_comb from inferring a latch.
  always_comb begin
    count_next = count_q;
    if (enable) begin
      count_next = (count_q == LAST_COUNT) ? 4'd0 : count_q + 4'd1;
    end
  end

  // Converter reads the current count, so segments lag saida by one cycle.
  always_comb seg_next = hex_to_seg(count_q) ^ SEG_POL;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
      seg_q   <= SEG_RESET;
    end else begin
      count_q <= count_next;
      seg_q   <= seg_next;
    end
  end

  assign saida = count_q;
  assign {s1, s2, s3, s4, s5, s6, s7} = seg_q;

endmodule

// File: tb/tb_contador_display.sv
// Randomized self-checking bench: default build plus a COUNT_MAX=9 / active-low instance,
// both compared against a cycle-level model built from the decimal/hex digit table.
module tb_contador_display;

  logic clock = 1'b0;
  logic reset;
  logic enable;

  logic [3:0] saida_a, saida_b;
  logic a1, a2, a3, a4, a5, a6, a7;
  logic b1, b2, b3, b4, b5, b6, b7;

  always #5 clock = ~clock;

  contador_display dut_a (
    .clock(clock), .reset(reset), .enable(enable), .saida(saida_a),
    .s1(a1), .s2(a2), .s3(a3), .s4(a4), .s5(a5), .s6(a6), .s7(a7)
  );

  contador_display #(.COUNT_MAX(9), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .saida(saida_b),
    .s1(b1), .s2(b2), .s3(b3), .s4(b4), .s5(b5), .s6(b6), .s7(b7)
  );

  // Digit shapes as drawn on the display, abcdefg, lit = 1.
  localparam logic [6:0] DIGITS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int n_tests = 0;
  int n_fail  = 0;

  int         m_cnt_a, m_cnt_b;
  logic [6:0] m_seg_a, m_seg_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int code, input bit active_low);
    logic [6:0] p;
`ifdef DISPLAY_HEX_EN
    p = DIGITS[code];
`else
    p = (code <= 9) ? DIGITS[code] : 7'b0000000;
`endif
    return active_low ? ~p : p;
  endfunction

  task automatic model_reset();
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_seg_a = ref_seg(0, 1'b0);
    m_seg_b = ref_seg(0, 1'b1);
  endtask

  task automatic model_edge(input bit en);
    m_seg_a = ref_seg(m_cnt_a, 1'b0);
    m_seg_b = ref_seg(m_cnt_b, 1'b1);
    if (en) begin
      m_cnt_a = (m_cnt_a + 1) % 16;
      m_cnt_b = (m_cnt_b + 1) % 10;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt_a"}, 32'(saida_a), 32'(m_cnt_a));
    check({tag, "_seg_a"}, 32'({a1, a2, a3, a4, a5, a6, a7}), 32'(m_seg_a));
    check({tag, "_cnt_b"}, 32'(saida_b), 32'(m_cnt_b));
    check({tag, "_seg_b"}, 32'({b1, b2, b3, b4, b5, b6, b7}), 32'(m_seg_b));
  endtask

  task automatic cycle(input bit en, input string tag);
    enable = en;
    @(posedge clock);
    model_edge(en);
    #1;
    check_all(tag);
  endtask

  // Short reset pulse placed between clock edges; state must clear without an edge.
  task automatic mid_reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    model_reset();
    #1;
    check_all("reset_t0");
    check("reset_seg_b_pattern", 32'({b1, b2, b3, b4, b5, b6, b7}), 32'(7'b0000001));
    @(posedge clock);
    #1;
    check_all("reset_held");
    reset = 1'b0;

    // Count 1..10 with one-cycle segment lag.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, "count_up");
      if (i == 3) begin
        check("edge3_saida", 32'(saida_a), 32'd3);
        check("edge3_seg", 32'({a1, a2, a3, a4, a5, a6, a7}), 32'(7'b1101101));
      end
    end

    // Complete 16 edges from 0: wrap 15 -> 0, segments show code 15 one cycle later.
    for (int i = 0; i < 6; i++) cycle(1'b1, "wrap");
    check("wrap_saida", 32'(saida_a), 32'd0);
    cycle(1'b1, "after_wrap");

    // Advance to 5, then hold with enable low.
    for (int i = 0; i < 4; i++) cycle(1'b1, "to_five");
    check("five_saida", 32'(saida_a), 32'd5);
    for (int i = 0; i < 3; i++) cycle(1'b0, "hold");
    check("hold_seg", 32'({a1, a2, a3, a4, a5, a6, a7}), 32'(7'b1011011));

    // Reach 9 and clear with a sub-period reset pulse.
    for (int i = 0; i < 4; i++) cycle(1'b1, "to_nine");
    mid_reset_pulse("mid_reset");
    check("mid_reset_seg", 32'({a1, a2, a3, a4, a5, a6, a7}), 32'(7'b1111110));
    cycle(1'b1, "resume");
    check("resume_saida", 32'(saida_a), 32'd1);

    // Randomized enable with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) mid_reset_pulse("rand_reset");
      else cycle(1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
